// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester.
// The master modport is the requester side; slave is the arbiter side.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory (2-cycle response).
// DMEM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of port-0 priority.
module dmem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          mem_writeEn,
    output logic          mem_readEn,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_WriteData,
    input  logic [DW-1:0] mem_ReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant_ok;
    logic          g0;
    logic          g1;
    logic          accept;
    logic          own;
    logic          oor;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          in_range;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic          last_gnt;
`endif

    assign p0.gnt = g0;
    assign p1.gnt = g1;

    assign sel_we    = g1 ? p1.we    : p0.we;
    assign sel_addr  = g1 ? p1.addr  : p0.addr;
    assign sel_wdata = g1 ? p1.wdata : p0.wdata;
    assign in_range  = sel_addr < AW'(DEPTH);

    always_comb begin
        state_nxt = state;
        g0        = 1'b0;
        g1        = 1'b0;
        grant_ok  = !rst && (state == IDLE || state == RESP);
        if (grant_ok) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            // last_gnt == 1 means port 1 won last, so port 0 takes the tie
            if (p0.req && p1.req) begin
                g0 = last_gnt;
                g1 = !last_gnt;
            end else begin
                g0 = p0.req;
                g1 = p1.req;
            end
`else
            g0 = p0.req;
            g1 = p1.req && !p0.req;
`endif
        end
        accept = g0 || g1;
        unique case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = accept ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            own           <= 1'b0;
            oor           <= 1'b0;
            mem_writeEn   <= 1'b0;
            mem_readEn    <= 1'b0;
            mem_address   <= '0;
            mem_WriteData <= '0;
            p0.rvalid     <= 1'b0;
            p0.err        <= 1'b0;
            p0.rdata      <= '0;
            p1.rvalid     <= 1'b0;
            p1.err        <= 1'b0;
            p1.rdata      <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_gnt      <= 1'b1;
`endif
        end else begin
            state       <= state_nxt;
            mem_writeEn <= 1'b0;
            mem_readEn  <= 1'b0;
            p0.rvalid   <= 1'b0;
            p0.err      <= 1'b0;
            p1.rvalid   <= 1'b0;
            p1.err      <= 1'b0;
            if (accept) begin
                own           <= g1;
                oor           <= !in_range;
                mem_address   <= sel_addr;
                mem_WriteData <= sel_wdata;
                mem_writeEn   <= sel_we && in_range;
                mem_readEn    <= !sel_we && in_range;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                last_gnt      <= g1;
`endif
            end
            // mem_readEn is high only for an in-range read
            if (state == ACCESS) begin
                if (own) begin
                    p1.rvalid <= 1'b1;
                    p1.err    <= oor;
                    p1.rdata  <= mem_readEn ? mem_ReadData : '0;
                end else begin
                    p0.rvalid <= 1'b1;
                    p0.err    <= oor;
                    p0.rdata  <= mem_readEn ? mem_ReadData : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024-word memory.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        mem_writeEn;
    logic        mem_readEn;
    logic [31:0] mem_address;
    logic [31:0] mem_WriteData;
    logic [31:0] mem_ReadData;
    logic [31:0] mem [1024];

    int n_cmp;
    int n_err;

    dmem_arbiter_if #(.AW(32), .DW(32)) p0_if ();
    dmem_arbiter_if #(.AW(32), .DW(32)) p1_if ();

    dmem_arbiter #(.DEPTH(1024), .DW(32), .AW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .p0            (p0_if),
        .p1            (p1_if),
        .mem_writeEn   (mem_writeEn),
        .mem_readEn    (mem_readEn),
        .mem_address   (mem_address),
        .mem_WriteData (mem_WriteData),
        .mem_ReadData  (mem_ReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory acts on the falling edge; its reset clears the contents
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 1024; k++) mem[k] <= '0;
            mem_ReadData <= '0;
        end else begin
            if (mem_writeEn) mem[mem_address[9:0]] <= mem_WriteData;
            if (mem_readEn) mem_ReadData <= mem[mem_address[9:0]];
        end
    end

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        g0;
        logic        g1;
        logic        v0;
        logic        e0;
        logic [31:0] q0;
        logic        v1;
        logic        e1;
        logic [31:0] q1;
        logic        mwe;
        logic        mre;
        logic [31:0] ma;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        p0_if.req   = r0;
        p0_if.we    = w0;
        p0_if.addr  = a0;
        p0_if.wdata = d0;
        p1_if.req   = r1;
        p1_if.we    = w1;
        p1_if.addr  = a1;
        p1_if.wdata = d1;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    function automatic int winner(input int i);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        return (i / 2) % 2;
`else
        return 0;
`endif
    endfunction

    localparam logic [31:0] B = 32'hDEADBEEF;
    localparam logic [31:0] C = 32'h12345678;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //           rst r0 w0 a0  d0 r1 w1 a1   d1 g0 g1 v0 e0 q0 v1 e1 q1 mwe mre ma
        tbl[0]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 5, B, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5};
        tbl[4]  = '{0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 1024, 0, 0, 1, 1, 0, B, 0, 0, 0, 0, 0, 5};
        tbl[7]  = '{0, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 0, 0, 0, 1024};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 1023, C, 0, 1, 0, 0, B, 1, 1, 0, 0, 0, 1024};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 0, 1, 0, 1023};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 1023, 0, 0, 1, 0, 0, B, 1, 0, 0, 0, 0, 1023};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 0, 0, 1, 1023};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B, 1, 0, C, 0, 0, 1023};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, B, 0, 0, C, 0, 0, 1023};

        for (int i = 0; i < 14; i++) begin
            step();
            rst = tbl[i].rst;
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #2;
            chk($sformatf("r%0d.g0", i), 32'(p0_if.gnt), 32'(tbl[i].g0));
            chk($sformatf("r%0d.g1", i), 32'(p1_if.gnt), 32'(tbl[i].g1));
            chk($sformatf("r%0d.v0", i), 32'(p0_if.rvalid), 32'(tbl[i].v0));
            chk($sformatf("r%0d.e0", i), 32'(p0_if.err), 32'(tbl[i].e0));
            chk($sformatf("r%0d.q0", i), p0_if.rdata, tbl[i].q0);
            chk($sformatf("r%0d.v1", i), 32'(p1_if.rvalid), 32'(tbl[i].v1));
            chk($sformatf("r%0d.e1", i), 32'(p1_if.err), 32'(tbl[i].e1));
            chk($sformatf("r%0d.q1", i), p1_if.rdata, tbl[i].q1);
            chk($sformatf("r%0d.mwe", i), 32'(mem_writeEn), 32'(tbl[i].mwe));
            chk($sformatf("r%0d.mre", i), 32'(mem_readEn), 32'(tbl[i].mre));
            chk($sformatf("r%0d.ma", i), mem_address, tbl[i].ma);
        end

        // contention: both ports read every cycle
        for (int i = 0; i < 8; i++) begin
            step();
            drive(1, 0, 1, 0, 1, 0, 2, 0);
            #2;
            if (i % 2 == 0) begin
                chk($sformatf("c%0d.g0", i), 32'(p0_if.gnt),
                    32'(winner(i) == 0));
                chk($sformatf("c%0d.g1", i), 32'(p1_if.gnt),
                    32'(winner(i) == 1));
                chk($sformatf("c%0d.v0", i), 32'(p0_if.rvalid),
                    32'(i > 0 && winner(i - 2) == 0));
                chk($sformatf("c%0d.v1", i), 32'(p1_if.rvalid),
                    32'(i > 0 && winner(i - 2) == 1));
            end else begin
                chk($sformatf("c%0d.gnt", i),
                    32'({p0_if.gnt, p1_if.gnt}), 32'(0));
                chk($sformatf("c%0d.mre", i), 32'(mem_readEn), 32'(1));
                chk($sformatf("c%0d.ma", i), mem_address,
                    32'(winner(i - 1) + 1));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // reset in the ACCESS cycle of a port-1 write
        drive(0, 0, 0, 0, 1, 1, 7, 32'hA5A5A5A5);
        #2;
        chk("rm.gntA", 32'(p1_if.gnt), 32'(1));
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        chk("rm.mweB", 32'(mem_writeEn), 32'(1));
        chk("rm.maB", mem_address, 32'd7);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 7, 0);
        #2;
        chk("rm.v1C", 32'(p1_if.rvalid), 32'(0));
        chk("rm.mweC", 32'(mem_writeEn), 32'(0));
        chk("rm.gntC", 32'(p1_if.gnt), 32'(1));
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rm.v1D", 32'(p1_if.rvalid), 32'(0));
        chk("rm.mreD", 32'(mem_readEn), 32'(1));
        step();
        #2;
        chk("rm.v1E", 32'(p1_if.rvalid), 32'(1));
        chk("rm.e1E", 32'(p1_if.err), 32'(0));
        chk("rm.q1E", p1_if.rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 1024-word data memory.
- Port 0 is the pipeline MEM stage; port 1 is the DMA/debug loader.
- Grants one access at a time, drives the memory enables, address and write data for exactly one cycle, and returns captured read data with a fixed 2-cycle latency.
- Flags out-of-range word addresses with an error response and no memory access.

Parameters:
- DEPTH, 1024: memory depth in words; a request is legal when addr < DEPTH.
- DW, 32: data width.
- AW, 32: address width. The address is a word index, passed to the memory unchanged.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 request; held with we/addr/wdata stable until accepted
- p0_we  in  1  1 = write, 0 = read
- p0_addr  in  AW  word address
- p0_wdata  in  DW  write data
- p0_gnt  out  1  combinational grant; accepted on the edge where req && gnt
- p0_rvalid  out  1  one-cycle response pulse
- p0_rdata  out  DW  read data; holds until the next port-0 response
- p0_err  out  1  valid with p0_rvalid; 1 = address out of range
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0
- mem_writeEn  out  1  memory write enable
- mem_readEn  out  1  memory read enable
- mem_address  out  AW  memory address
- mem_WriteData  out  DW  memory write data
- mem_ReadData  in  DW  memory read data; valid before the rising edge that ends the access cycle

Behaviour:
- State machine states: IDLE, ACCESS, RESP.
- Reset:
  - state = IDLE; all gnt, rvalid, err, mem_writeEn and mem_readEn = 0.
  - rdata, mem_address and mem_WriteData = 0.
  - gnt is forced to 0 while rst is high.
- Grant:
  - gnt is asserted only in IDLE or RESP, to at most one port.
  - Fixed priority: port 0 wins when both ports request.
- Accept (edge k, req && gnt):
  - Register port id, we, addr, wdata and range flag (addr >= DEPTH).
  - Move to ACCESS.
- ACCESS (cycle k to k+1):
  - In range: mem_address = addr; mem_writeEn = we; mem_readEn = !we; mem_WriteData = wdata.
  - Out of range: both enables 0; address/data still driven.
  - The memory performs the operation on its falling edge inside this cycle.
  - Enables are high for exactly one cycle per accepted request.
- Edge k+1:
  - In-range read: capture mem_ReadData into the owning port's rdata.
  - Write or out-of-range access: rdata = 0.
  - Move to RESP.
- RESP (cycle k+1 to k+2):
  - Owning port: rvalid = 1; err = range flag.
  - The other port's rvalid stays 0.
  - A new grant may be issued in this cycle (back-to-back). Accept at edge k+2 goes to ACCESS, otherwise to IDLE.
  - Peak throughput is one access per 2 cycles.
- Latency: rvalid is high exactly 1 cycle after the accept edge, for one cycle.
- Boundary conditions:
  - rst asserted mid-transaction: the edge returns to IDLE; no rvalid is issued; in-flight enables drop on the next cycle.
  - The memory's own rst clears its contents; the arbiter issues no access while rst is high.
  - req deasserted before grant: no effect, no response.
  - addr == DEPTH-1 is legal; addr == DEPTH gives err = 1.
  - Simultaneous requests in RESP follow the same priority rule as in IDLE.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. On a tie, the port not granted most recently wins. The last-granted register resets to port 1, so port 0 wins the first tie. Single requests are granted as normal.
- Undefined: fixed priority, port 0 always wins ties; port 1 can starve.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles -> all outputs 0, mem enables 0, both gnt 0 even with req = 1.
- Write then read on port 0: write addr 5, data 0xDEADBEEF, then read addr 5 -> mem_writeEn pulses 1 cycle, p0_rvalid 1 cycle after each accept, read returns p0_rdata = 0xDEADBEEF with p0_err = 0.
- Out of range on port 1: read addr 1024 -> no mem enable asserted, p1_rvalid with p1_err = 1 and p1_rdata = 0; addr 1023 -> err = 0.
- Contention: both ports request reads every cycle (p0 addr 1, p1 addr 2).
  - Macro undefined: only p0 granted.
  - Macro defined: grants alternate p0, p1, p0, ...
  - Back-to-back grants arrive every 2 cycles.
- Reset mid-transaction: accept p1 write to addr 7, assert rst in the ACCESS cycle -> no p1_rvalid, state IDLE, a subsequent read of addr 7 returns 0.
